wb_stage_pipe: RTL and testbench

Parametrised writeback stage for the RV32i 5-stage pipeline. It absorbs the MEM/WB pipeline register and performs load byte/halfword extraction with sign/zero extension. It selects among four result sources and drives the register-file write port and the forwarding path to the decode and execute stages. It also tracks retirement with a once-per-instruction retire pulse and a retire counter.

---
 rtl/wb_stage_pipe.sv | 182 ++++++++++++++++++
 tb/tb_wb_stage_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_pipe.sv
// Writeback stage: MEM/WB register, load extraction, result select, retire tracking.
// Latency: one cycle from M inputs to W outputs; ResultW is combinational from W registers.
// Backpressure: StallW holds the W slot (one retire pulse only); FlushW turns it into a bubble.
// Optional feature macro: WB_RVFI_EN adds RVFI trace ports (InstrM/PCM in, rvfi_* out).
module wb_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallW,
  input  logic             FlushW,
  input  logic             ValidM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdM,
  input  logic [1:0]       ResultSrcM,
  input  logic [2:0]       Funct3M,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  ReadDataM,
  input  logic [XLEN-1:0]  PCPlus4M,
  input  logic [XLEN-1:0]  ImmExtM,
  output logic [XLEN-1:0]  ResultW,
  output logic [4:0]       RdW,
  output logic             RegWriteW,
  output logic             ValidW,
  output logic             RetireW,
  output logic [RET_W-1:0] RetireCnt
`ifdef WB_RVFI_EN
  ,
  input  logic [31:0]      InstrM,
  input  logic [XLEN-1:0]  PCM,
  output logic             rvfi_valid,
  output logic [63:0]      rvfi_order,
  output logic [31:0]      rvfi_insn,
  output logic [XLEN-1:0]  rvfi_pc_rdata,
  output logic [4:0]       rvfi_rd_addr,
  output logic [XLEN-1:0]  rvfi_rd_wdata,
  output logic             rvfi_trap,
  output logic             rvfi_halt,
  output logic             rvfi_intr,
  output logic [1:0]       rvfi_mode,
  output logic [1:0]       rvfi_ixl
`endif
);

  logic             valid_q;
  logic             regwrite_q;
  logic             retired_q;
  logic [4:0]       rd_q;
  logic [1:0]       src_q;
  logic [2:0]       funct3_q;
  logic [XLEN-1:0]  alu_q;
  logic [XLEN-1:0]  rdata_q;
  logic [XLEN-1:0]  pc4_q;
  logic [XLEN-1:0]  imm_q;
  logic [RET_W-1:0] cnt_q;

  logic             retire;
  logic [31:0]      word;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [XLEN-1:0]  load_val;
  logic [XLEN-1:0]  result;

  // A valid instruction retires in the first cycle it sits in W; the flag blocks repeats under stall.
  assign retire = valid_q & ~retired_q;

  // W register: flush beats stall beats load; a fresh load re-arms the retire pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      retired_q  <= 1'b0;
      rd_q       <= '0;
      src_q      <= '0;
      funct3_q   <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
    end else if (FlushW) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      retired_q  <= 1'b0;
    end else if (StallW) begin
      retired_q  <= retired_q | retire;
    end else begin
      valid_q    <= ValidM;
      regwrite_q <= RegWriteM;
      retired_q  <= 1'b0;
      rd_q       <= RdM;
      src_q      <= ResultSrcM;
      funct3_q   <= Funct3M;
      alu_q      <= ALUResultM;
      rdata_q    <= ReadDataM;
      pc4_q      <= PCPlus4M;
      imm_q      <= ImmExtM;
    end
  end

  // Retire counter wraps freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (retire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Load extraction from the aligned word using the registered byte offset.
  always_comb begin
    word     = rdata_q[31:0];
    byte_sel = word[{alu_q[1:0], 3'b000} +: 8];
    half_sel = alu_q[1] ? word[31:16] : word[15:0];
    load_val = rdata_q;
    case (funct3_q)
      3'b000:  load_val = XLEN'($signed(byte_sel));
      3'b100:  load_val = XLEN'(byte_sel);
      3'b001:  load_val = XLEN'($signed(half_sel));
      3'b101:  load_val = XLEN'(half_sel);
      3'b010:  load_val = XLEN'($signed(word));
      default: load_val = rdata_q;
    endcase
  end

  // Result source select.
  always_comb begin
    result = alu_q;
    case (src_q)
      2'b00:   result = alu_q;
      2'b01:   result = load_val;
      2'b10:   result = pc4_q;
      default: result = imm_q;
    endcase
  end

  assign ResultW   = result;
  assign RdW       = rd_q;
  assign RegWriteW = regwrite_q & valid_q & (rd_q != 5'd0);
  assign ValidW    = valid_q;
  assign RetireW   = retire;
  assign RetireCnt = cnt_q;

`ifdef WB_RVFI_EN
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic [63:0]     order_q;

  // Trace fields travel with the instruction, under the same flush/stall rules.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (!FlushW && !StallW) begin
      instr_q <= InstrM;
      pc_q    <= PCM;
    end
  end

  // Order reports the value before this retirement's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_q <= '0;
    end else if (retire) begin
      order_q <= order_q + 64'd1;
    end
  end

  assign rvfi_valid    = retire;
  assign rvfi_order    = order_q;
  assign rvfi_insn     = instr_q;
  assign rvfi_pc_rdata = pc_q;
  assign rvfi_rd_addr  = RegWriteW ? rd_q : 5'd0;
  assign rvfi_rd_wdata = RegWriteW ? result : '0;
  assign rvfi_trap     = 1'b0;
  assign rvfi_halt     = 1'b0;
  assign rvfi_intr     = 1'b0;
  assign rvfi_mode     = 2'b11;
  assign rvfi_ixl      = 2'b01;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: directed load/select/x0/stall/flush/reset cases plus random traffic.
// Expected retirements are queued at issue time; a negedge monitor checks each RetireW pulse.
// Retire counter is narrowed so wrap-around happens naturally during the run.
module tb_wb_stage_pipe;
  localparam int XLEN  = 32;
  localparam int RET_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             StallW, FlushW, ValidM, RegWriteM;
  logic [4:0]       RdM;
  logic [1:0]       ResultSrcM;
  logic [2:0]       Funct3M;
  logic [XLEN-1:0]  ALUResultM, ReadDataM, PCPlus4M, ImmExtM;
  logic [XLEN-1:0]  ResultW;
  logic [4:0]       RdW;
  logic             RegWriteW, ValidW, RetireW;
  logic [RET_W-1:0] RetireCnt;

  always #5 clk = ~clk;

  wb_stage_pipe #(.XLEN(XLEN), .RET_W(RET_W)) dut (
    .clk(clk), .rst_n(rst_n), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .RdM(RdM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW), .ValidW(ValidW),
    .RetireW(RetireW), .RetireCnt(RetireCnt)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          retired_n = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference result computed directly from the ISA load/select rules.
  function automatic logic [31:0] model(input logic [1:0] src, input logic [2:0] f3,
                                        input logic [31:0] alu, input logic [31:0] rdata,
                                        input logic [31:0] pc4, input logic [31:0] imm);
    int unsigned off, b, h;
    off = alu % 4;
    b   = (rdata >> (8 * off)) % 256;
    h   = (rdata >> (16 * (off / 2))) % 65536;
    case (src)
      2'd0: return alu;
      2'd2: return pc4;
      2'd3: return imm;
      default: begin
        case (f3)
          3'd0:    return (b >= 128) ? b - 256 : b;
          3'd4:    return b;
          3'd1:    return (h >= 32768) ? h - 65536 : h;
          3'd5:    return h;
          default: return rdata;
        endcase
      end
    endcase
  endfunction

  // Drive one cycle of M-stage inputs; queue the expectation if it will enter W.
  task automatic issue(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] src,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4, input logic [31:0] imm,
                       input logic stall, input logic flush, input logic [31:0] exp_res);
    exp_t e;
    @(posedge clk);
    #1;
    ValidM = v; RegWriteM = rw; RdM = rd; ResultSrcM = src; Funct3M = f3;
    ALUResultM = alu; ReadDataM = rdata; PCPlus4M = pc4; ImmExtM = imm;
    StallW = stall; FlushW = flush;
    if (v && !stall && !flush) begin
      e.res = exp_res;
      e.rd  = rd;
      e.we  = rw && (rd != 5'd0);
      q.push_back(e);
    end
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic rand_issue(input logic stall, input logic flush);
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] alu, rdata, pc4, imm;
    src = 2'($urandom_range(0, 3));
    f3 = 3'($urandom_range(0, 7));
    alu = $urandom; rdata = $urandom; pc4 = $urandom; imm = $urandom;
    issue(($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom_range(0, 31)), src, f3,
          alu, rdata, pc4, imm, stall, flush, model(src, f3, alu, rdata, pc4, imm));
  endtask

  // Monitor: every retire pulse consumes one expectation; held instructions must stay stable.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && RetireW) begin
        if (q.size() == 0) begin
          chk("spurious_retire", 32'(RetireW), 32'd0);
        end else begin
          e = q.pop_front();
          chk("result", ResultW, e.res);
          chk("rd", 32'(RdW), 32'(e.rd));
          chk("regwrite", 32'(RegWriteW), 32'(e.we));
          chk("retire_cnt", 32'(RetireCnt), 32'(retired_n % 16));
          retired_n++;
          last_res = e.res;
          last_rd  = e.rd;
        end
      end else if (rst_n && ValidW) begin
        chk("held_result", ResultW, last_res);
        chk("held_rd", 32'(RdW), 32'(last_rd));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ValidM = 0; RegWriteM = 0; RdM = 0; ResultSrcM = 0; Funct3M = 0;
    ALUResultM = 0; ReadDataM = 0; PCPlus4M = 0; ImmExtM = 0; StallW = 0; FlushW = 0;
    #2;
    chk("rst_valid", 32'(ValidW), 32'd0);
    chk("rst_regwrite", 32'(RegWriteW), 32'd0);
    chk("rst_rd", 32'(RdW), 32'd0);
    chk("rst_result", ResultW, 32'd0);
    chk("rst_retire", 32'(RetireW), 32'd0);
    chk("rst_cnt", 32'(RetireCnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Load extraction on 0x80FF7F01.
    issue(1, 1, 5'd1, 2'd1, 3'd0, 32'h100, 32'h80FF7F01, 0, 0, 0, 0, 32'h00000001);
    issue(1, 1, 5'd1, 2'd1, 3'd0, 32'h101, 32'h80FF7F01, 0, 0, 0, 0, 32'h0000007F);
    issue(1, 1, 5'd1, 2'd1, 3'd0, 32'h102, 32'h80FF7F01, 0, 0, 0, 0, 32'hFFFFFFFF);
    issue(1, 1, 5'd1, 2'd1, 3'd0, 32'h103, 32'h80FF7F01, 0, 0, 0, 0, 32'hFFFFFF80);
    issue(1, 1, 5'd2, 2'd1, 3'd4, 32'h103, 32'h80FF7F01, 0, 0, 0, 0, 32'h00000080);
    issue(1, 1, 5'd3, 2'd1, 3'd1, 32'h102, 32'h80FF7F01, 0, 0, 0, 0, 32'hFFFF80FF);
    issue(1, 1, 5'd4, 2'd1, 3'd5, 32'h102, 32'h80FF7F01, 0, 0, 0, 0, 32'h000080FF);
    issue(1, 1, 5'd4, 2'd1, 3'd2, 32'h100, 32'h80FF7F01, 0, 0, 0, 0, 32'h80FF7F01);
    // Source select.
    issue(1, 1, 5'd6, 2'd0, 3'd0, 32'h11, 0, 32'h104, 32'h12345000, 0, 0, 32'h00000011);
    issue(1, 1, 5'd6, 2'd2, 3'd0, 32'h11, 0, 32'h104, 32'h12345000, 0, 0, 32'h00000104);
    issue(1, 1, 5'd6, 2'd3, 3'd0, 32'h11, 0, 32'h104, 32'h12345000, 0, 0, 32'h12345000);
    // x0 suppression then rd=5.
    issue(1, 1, 5'd0, 2'd0, 3'd0, 32'h55, 0, 0, 0, 0, 0, 32'h00000055);
    issue(1, 1, 5'd5, 2'd0, 3'd0, 32'h55, 0, 0, 0, 0, 0, 32'h00000055);
    // Stall for three cycles on a valid instruction with churning M inputs.
    issue(1, 1, 5'd7, 2'd0, 3'd0, 32'hCAFE0001, 0, 0, 0, 0, 0, 32'hCAFE0001);
    repeat (3) rand_issue(1'b1, 1'b0);
    issue(1, 1, 5'd8, 2'd3, 3'd0, 0, 0, 0, 32'hBEEF0000, 0, 0, 32'hBEEF0000);
    // Flush and stall together: W becomes a bubble with no retire.
    issue(1, 1, 5'd9, 2'd0, 3'd0, 32'h99, 0, 0, 0, 1, 1, 32'h0);
    idle();
    @(negedge clk);
    #1;
    chk("flush_valid", 32'(ValidW), 32'd0);
    chk("flush_retire", 32'(RetireW), 32'd0);
    chk("flush_regwrite", 32'(RegWriteW), 32'd0);

    // Asynchronous reset mid-stream with a valid instruction in W.
    issue(1, 1, 5'd10, 2'd0, 3'd0, 32'h1234, 0, 0, 0, 0, 0, 32'h1234);
    idle();
    @(negedge clk);
    #1;
    chk("pre_reset_valid", 32'(ValidW), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ValidW), 32'd0);
    chk("arst_regwrite", 32'(RegWriteW), 32'd0);
    chk("arst_rd", 32'(RdW), 32'd0);
    chk("arst_result", ResultW, 32'd0);
    chk("arst_retire", 32'(RetireW), 32'd0);
    chk("arst_cnt", 32'(RetireCnt), 32'd0);
    q.delete();
    retired_n = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic; the narrow counter wraps many times.
    for (int i = 0; i < 400; i++) begin
      rand_issue(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && q.size() != 0; i++) idle();
    repeat (2) idle();
    chk("drain_empty", 32'(q.size()), 32'd0);
    @(negedge clk);
    chk("final_cnt", 32'(RetireCnt), 32'(retired_n % 16));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
